// File: rtl/ccc_lock_reset_sequencer_if.sv
// CCC supervisor bundle: lock inputs, status and control in,
// staged reset and status outputs out.
interface ccc_lock_reset_sequencer_if;
  logic       FAB_LOCK;
  logic       MSS_LOCK;
  logic       REQUIRE_MSS_LOCK;
  logic       CLR_STATUS;
  logic       CORE_RESET;
  logic       PERIPH_RESET;
  logic       READY;
  logic       LOCK_LOST;
  logic       TIMEOUT_ERR;
  logic [7:0] LOSS_COUNT;
  logic [1:0] STATE;

  modport master (
    output FAB_LOCK, MSS_LOCK,
    output REQUIRE_MSS_LOCK, CLR_STATUS,
    input  CORE_RESET, PERIPH_RESET, READY,
    input  LOCK_LOST, TIMEOUT_ERR,
    input  LOSS_COUNT, STATE
  );

  modport slave (
    input  FAB_LOCK, MSS_LOCK,
    input  REQUIRE_MSS_LOCK, CLR_STATUS,
    output CORE_RESET, PERIPH_RESET, READY,
    output LOCK_LOST, TIMEOUT_ERR,
    output LOSS_COUNT, STATE
  );
endinterface

// File: rtl/ccc_lock_reset_sequencer.sv
// CCC lock supervisor: qualifies synchronized lock, then
// releases core reset and peripheral reset in stages.
module ccc_lock_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGE_DELAY    = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 17
) (
  input  logic FAB_CLK,
  input  logic FAB_RESET,
  ccc_lock_reset_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    WAIT_LOCK    = 2'd0,
    STABILIZE    = 2'd1,
    RELEASE_CORE = 2'd2,
    RUN          = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST =
    CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TMR_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMR_HIT =
    CNT_W'(TIMEOUT_CYCLES - 2);

  state_t                 state;
  logic [SYNC_STAGES-1:0] fab_sync;
  logic [SYNC_STAGES-1:0] mss_sync;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       tmr;
  logic                   fab_s;
  logic                   mss_s;
  logic                   lock_q;
  logic                   loss;
  logic                   tmr_run;
  logic                   tmr_hit;

  assign fab_s   = fab_sync[SYNC_STAGES-1];
  assign mss_s   = mss_sync[SYNC_STAGES-1];
  // REQUIRE_MSS_LOCK bypasses the synchronizers on purpose
  assign lock_q  = fab_s & (mss_s | ~bus.REQUIRE_MSS_LOCK);
  assign loss    = ~lock_q &
                   (state == RELEASE_CORE || state == RUN);
  assign tmr_run = (state == WAIT_LOCK || state == STABILIZE);
  assign tmr_hit = tmr_run && (tmr == TMR_HIT);
  assign bus.STATE = state;

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      state            <= WAIT_LOCK;
      fab_sync         <= '0;
      mss_sync         <= '0;
      cnt              <= '0;
      tmr              <= '0;
      bus.CORE_RESET   <= 1'b1;
      bus.PERIPH_RESET <= 1'b1;
      bus.READY        <= 1'b0;
      bus.LOCK_LOST    <= 1'b0;
      bus.TIMEOUT_ERR  <= 1'b0;
      bus.LOSS_COUNT   <= '0;
    end else begin
      fab_sync <= {fab_sync[SYNC_STAGES-2:0], bus.FAB_LOCK};
      mss_sync <= {mss_sync[SYNC_STAGES-2:0], bus.MSS_LOCK};

      if (tmr_run)
        tmr <= (tmr == TMR_LAST) ? '0 : tmr + CNT_W'(1);

      if (tmr_hit)
        bus.TIMEOUT_ERR <= 1'b1;
      else if (bus.CLR_STATUS)
        bus.TIMEOUT_ERR <= 1'b0;

      // a coincident clear restarts the count at this event
      if (loss) begin
        bus.LOCK_LOST <= 1'b1;
        if (bus.CLR_STATUS)
          bus.LOSS_COUNT <= 8'd1;
        else if (bus.LOSS_COUNT != 8'hFF)
          bus.LOSS_COUNT <= bus.LOSS_COUNT + 8'd1;
      end else if (bus.CLR_STATUS) begin
        bus.LOCK_LOST  <= 1'b0;
        bus.LOSS_COUNT <= '0;
      end

      unique case (state)
        WAIT_LOCK: begin
          if (lock_q) begin
            state <= STABILIZE;
            cnt   <= '0;
          end
        end
        STABILIZE: begin
          if (!lock_q) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state          <= RELEASE_CORE;
            cnt            <= '0;
            bus.CORE_RESET <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE_CORE: begin
          if (loss) begin
            state            <= WAIT_LOCK;
            cnt              <= '0;
            tmr              <= '0;
            bus.CORE_RESET   <= 1'b1;
            bus.PERIPH_RESET <= 1'b1;
            bus.READY        <= 1'b0;
          end else if (cnt == DELAY_LAST) begin
            state            <= RUN;
            cnt              <= '0;
            bus.PERIPH_RESET <= 1'b0;
            bus.READY        <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (loss) begin
            state            <= WAIT_LOCK;
            cnt              <= '0;
            tmr              <= '0;
            bus.CORE_RESET   <= 1'b1;
            bus.PERIPH_RESET <= 1'b1;
            bus.READY        <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ccc_lock_reset_sequencer.sv
// Directed bench for ccc_lock_reset_sequencer: expectations
// are queued with a target edge and checked when it arrives.
module tb_ccc_lock_reset_sequencer;
  typedef enum int {
    S_STATE, S_CORE, S_PERIPH, S_READY, S_LOST, S_TO, S_CNT
  } sig_e;

  typedef struct {
    int          at;
    sig_e        sig;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ecnt = 0;

  ccc_lock_reset_sequencer_if bus ();

  ccc_lock_reset_sequencer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .STAGE_DELAY   (4),
    .TIMEOUT_CYCLES(32),
    .CNT_W         (6)
  ) dut (
    .FAB_CLK  (clk),
    .FAB_RESET(rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(sig_e s);
    logic [31:0] v;
    v = '0;
    case (s)
      S_STATE:  v = 32'(bus.STATE);
      S_CORE:   v = 32'(bus.CORE_RESET);
      S_PERIPH: v = 32'(bus.PERIPH_RESET);
      S_READY:  v = 32'(bus.READY);
      S_LOST:   v = 32'(bus.LOCK_LOST);
      S_TO:     v = 32'(bus.TIMEOUT_ERR);
      S_CNT:    v = 32'(bus.LOSS_COUNT);
      default:  v = 'x;
    endcase
    return v;
  endfunction

  task automatic push(int rel, sig_e s, logic [31:0] v,
                      string t);
    exp_t e;
    int   i;
    e = '{ecnt + rel, s, v, t};
    i = sb.size();
    while (i > 0 && sb[i-1].at > e.at) i--;
    sb.insert(i, e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0 && sb[0].at <= ecnt) begin
      e = sb.pop_front();
      o = obs(e.sig);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s edge %0d: got %0h expected %0h",
               e.tag, e.at, o, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
    drain();
  endtask

  task automatic rebase();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $error("FAIL %s: edge %0d never reached (now %0d)",
             e.tag, e.at, ecnt);
    end
    ecnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rebase();
  endtask

  task automatic bringup_checks(string p);
    push(2,  S_STATE,  0, {p, "_wait"});
    push(3,  S_STATE,  1, {p, "_stab"});
    push(10, S_CORE,   1, {p, "_core_hold"});
    push(11, S_CORE,   0, {p, "_core_rel"});
    push(11, S_STATE,  2, {p, "_relcore"});
    push(11, S_PERIPH, 1, {p, "_per_hold"});
    push(14, S_READY,  0, {p, "_rdy_hold"});
    push(15, S_PERIPH, 0, {p, "_per_rel"});
    push(15, S_READY,  1, {p, "_ready"});
    push(15, S_STATE,  3, {p, "_run"});
  endtask

  initial begin
    bus.FAB_LOCK         = 1'b0;
    bus.MSS_LOCK         = 1'b0;
    bus.REQUIRE_MSS_LOCK = 1'b1;
    bus.CLR_STATUS       = 1'b0;

    // clean bring-up
    do_reset();
    push(0, S_CORE,   1, "rst_core");
    push(0, S_PERIPH, 1, "rst_per");
    push(0, S_READY,  0, "rst_ready");
    push(0, S_LOST,   0, "rst_lost");
    push(0, S_TO,     0, "rst_to");
    push(0, S_CNT,    0, "rst_cnt");
    push(0, S_STATE,  0, "rst_state");
    drain();
    bus.FAB_LOCK = 1'b1;
    bus.MSS_LOCK = 1'b1;
    bringup_checks("clean");
    push(15, S_LOST, 0, "clean_lost");
    push(15, S_TO,   0, "clean_to");
    push(15, S_CNT,  0, "clean_cnt");
    repeat (15) step();

    // glitchy lock
    bus.FAB_LOCK = 1'b0;
    do_reset();
    bus.FAB_LOCK = 1'b1;
    push(7,  S_STATE, 1, "gl_stab");
    push(8,  S_STATE, 0, "gl_drop");
    push(9,  S_STATE, 1, "gl_restab");
    push(16, S_CORE,  1, "gl_core_hold");
    push(17, S_CORE,  0, "gl_core_rel");
    push(17, S_STATE, 2, "gl_relcore");
    push(21, S_STATE, 3, "gl_run");
    repeat (5) step();
    bus.FAB_LOCK = 1'b0;
    step();
    bus.FAB_LOCK = 1'b1;
    repeat (15) step();

    // loss in RUN and relock
    rebase();
    push(2,  S_READY,  1, "loss_pre");
    push(3,  S_CORE,   1, "loss_core");
    push(3,  S_PERIPH, 1, "loss_per");
    push(3,  S_READY,  0, "loss_ready");
    push(3,  S_STATE,  0, "loss_state");
    push(3,  S_LOST,   1, "loss_lost");
    push(3,  S_CNT,    1, "loss_cnt");
    push(4,  S_STATE,  1, "loss_stab");
    push(12, S_CORE,   0, "loss_core_rel");
    push(16, S_READY,  1, "loss_run");
    bus.MSS_LOCK = 1'b0;
    step();
    bus.MSS_LOCK = 1'b1;
    repeat (15) step();

    // 299 further losses; count saturates
    for (int i = 2; i <= 300; i++) begin
      rebase();
      push(3, S_CNT, (i > 255) ? 255 : i, "sat_cnt");
      if (i == 300) push(16, S_READY, 1, "sat_run");
      bus.MSS_LOCK = 1'b0;
      step();
      bus.MSS_LOCK = 1'b1;
      repeat (15) step();
    end

    // MSS lock not required, then required in RUN
    bus.FAB_LOCK = 1'b0;
    bus.MSS_LOCK = 1'b0;
    do_reset();
    bus.REQUIRE_MSS_LOCK = 1'b0;
    bus.FAB_LOCK = 1'b1;
    bringup_checks("nomss");
    repeat (15) step();
    rebase();
    bus.REQUIRE_MSS_LOCK = 1'b1;
    push(1, S_STATE, 0, "req_state");
    push(1, S_CORE,  1, "req_core");
    push(1, S_READY, 0, "req_ready");
    push(1, S_LOST,  1, "req_lost");
    push(1, S_CNT,   1, "req_cnt");
    push(5, S_STATE, 0, "req_wait");
    repeat (5) step();

    // timeout, clear, and re-timeout
    bus.FAB_LOCK = 1'b0;
    do_reset();
    push(30, S_TO,    0, "to_before");
    push(31, S_TO,    1, "to_set");
    push(31, S_STATE, 0, "to_state");
    push(41, S_TO,    0, "to_clr");
    push(62, S_TO,    0, "to_before2");
    push(63, S_TO,    1, "to_set2");
    push(63, S_STATE, 0, "to_state2");
    push(70, S_TO,    1, "to_hold");
    repeat (40) step();
    bus.CLR_STATUS = 1'b1;
    step();
    bus.CLR_STATUS = 1'b0;
    repeat (29) step();

    // bring up, one loss, then a loss with a coincident clear
    rebase();
    bus.FAB_LOCK = 1'b1;
    bus.MSS_LOCK = 1'b1;
    push(15, S_STATE, 3, "clr_run");
    repeat (15) step();
    rebase();
    push(3,  S_CNT,   1, "clr_first_cnt");
    push(16, S_READY, 1, "clr_relock");
    bus.MSS_LOCK = 1'b0;
    step();
    bus.MSS_LOCK = 1'b1;
    repeat (15) step();
    rebase();
    push(2,  S_CNT,   1, "clr_pre_cnt");
    push(2,  S_TO,    1, "clr_pre_to");
    push(3,  S_LOST,  1, "clr_lost");
    push(3,  S_CNT,   1, "clr_cnt");
    push(3,  S_TO,    0, "clr_to");
    push(3,  S_STATE, 0, "clr_state");
    push(12, S_STATE, 2, "mid_relcore");
    push(12, S_CORE,  0, "mid_core_rel");
    push(13, S_STATE, 2, "mid_relcore2");
    bus.MSS_LOCK = 1'b0;
    step();
    bus.MSS_LOCK = 1'b1;
    step();
    bus.CLR_STATUS = 1'b1;
    step();
    bus.CLR_STATUS = 1'b0;
    repeat (10) step();

    // reset during RELEASE_CORE, lock held high
    push(1, S_CORE,   1, "mid_core");
    push(1, S_PERIPH, 1, "mid_per");
    push(1, S_STATE,  0, "mid_state");
    push(1, S_LOST,   0, "mid_lost");
    push(1, S_CNT,    0, "mid_cnt");
    push(1, S_TO,     0, "mid_to");
    do_reset();
    bringup_checks("mid");
    repeat (15) step();

    rebase();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ccc_lock_reset_sequencer.md
Name: ccc_lock_reset_sequencer

Overview:
- Fabric-side supervisor for the MSS clock conditioning circuit (CCC).
- Synchronizes the CCC lock outputs and requires lock to be stable before releasing resets.
- Releases core logic reset first, then peripheral reset, in that order.
- On lock loss, re-asserts both resets, records the event and restarts the sequence. Also flags a CCC that fails to lock within a timeout.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each lock-input synchronizer (min 2)
STABLE_CYCLES, 1024, consecutive qualified-lock cycles needed before reset release (min 1)
STAGE_DELAY, 16, cycles between core-reset release and peripheral-reset release (min 1)
TIMEOUT_CYCLES, 65536, cycles without completing stabilization before TIMEOUT_ERR sets (min 2)
CNT_W, 17, counter width; must satisfy 2^CNT_W > max(STABLE_CYCLES, STAGE_DELAY, TIMEOUT_CYCLES)

Ports:
FAB_CLK  input  1  fabric clock (GLA0 domain); all logic is on its rising edge
FAB_RESET  input  1  synchronous, active-high reset
FAB_LOCK  input  1  CCC fabric lock, asynchronous
MSS_LOCK  input  1  CCC MSS lock, asynchronous
REQUIRE_MSS_LOCK  input  1  quasi-static; 1 = MSS_LOCK is also required for qualification
CLR_STATUS  input  1  single-cycle pulse; clears the sticky status outputs
CORE_RESET  output  1  active-high reset for core fabric logic
PERIPH_RESET  output  1  active-high reset for fabric peripherals
READY  output  1  high only in RUN
LOCK_LOST  output  1  sticky: lock was lost after CORE_RESET had been released
TIMEOUT_ERR  output  1  sticky: lock timeout occurred
LOSS_COUNT  output  8  lock-loss event count, saturates at 255
STATE  output  2  current state encoding, for debug

Behaviour:
- All outputs are registered.
- Reset values: CORE_RESET=1, PERIPH_RESET=1, READY=0, LOCK_LOST=0, TIMEOUT_ERR=0, LOSS_COUNT=0, STATE=WAIT_LOCK. Synchronizers and counters clear to 0.
- FAB_RESET asserted in any state forces the reset values on the next edge. Reset mid-sequence aborts the sequence with no residual count.
- Synchronization: each lock input passes through its own SYNC_STAGES-deep chain.
- Qualified lock: lock_q = fab_s & (mss_s | ~REQUIRE_MSS_LOCK).
- State encoding: WAIT_LOCK=0, STABILIZE=1, RELEASE_CORE=2, RUN=3.
- WAIT_LOCK:
  - Both resets are 1.
  - lock_q=1 → STABILIZE, with the stable counter cleared.
- STABILIZE:
  - Both resets are 1.
  - The stable counter increments on each cycle with lock_q=1.
  - lock_q=0 → WAIT_LOCK, stable counter cleared.
  - Counter reaches STABLE_CYCLES → RELEASE_CORE.
- Timeout timer:
  - Runs in WAIT_LOCK and STABILIZE. Clears on entering WAIT_LOCK from RELEASE_CORE or RUN, and on FAB_RESET.
  - On reaching TIMEOUT_CYCLES-1: sets TIMEOUT_ERR and wraps to 0. The state is unaffected and the sequencer keeps waiting.
- RELEASE_CORE:
  - CORE_RESET=0 and PERIPH_RESET=1.
  - The delay counter counts STAGE_DELAY cycles, then → RUN.
- RUN: CORE_RESET=0, PERIPH_RESET=0, READY=1.
- Lock loss (lock_q=0 in RELEASE_CORE or RUN):
  - Next edge: state → WAIT_LOCK; CORE_RESET, PERIPH_RESET =1; READY=0.
  - LOCK_LOST=1.
  - LOSS_COUNT increments, holding at 255.
  - Resets reassert one cycle after lock_q falls.
- Lock loss in WAIT_LOCK or STABILIZE is not a loss event.
- Release latency: a lock edge registered at edge 0 gives lock_q=1 after edge SYNC_STAGES, so:
  - STATE=STABILIZE after edge SYNC_STAGES+1.
  - CORE_RESET=0 after edge SYNC_STAGES+1+STABLE_CYCLES.
  - PERIPH_RESET=0 and READY=1 STAGE_DELAY edges after that.
- CLR_STATUS clears LOCK_LOST, TIMEOUT_ERR and LOSS_COUNT. If a set or increment event occurs in the same cycle, the event wins: flag=1 and LOSS_COUNT=1.
- REQUIRE_MSS_LOCK changes take effect through lock_q immediately. A change that drops lock_q in RUN counts as a loss.

Test Plan:
Test parameters: SYNC_STAGES=2, STABLE_CYCLES=8, STAGE_DELAY=4, TIMEOUT_CYCLES=32.
- Clean bring-up: FAB_LOCK=MSS_LOCK=1 registered at edge 0, REQUIRE_MSS_LOCK=1 → STATE=1 after edge 3; CORE_RESET=0 after edge 11; PERIPH_RESET=0 and READY=1 after edge 15; STATE=3; no status flags set.
- Glitchy lock: FAB_LOCK high for 5 cycles, low for 1, then high → STATE returns to 0, then restarts STABILIZE; CORE_RESET stays 1 until 8 consecutive locked cycles have completed.
- Loss in RUN: from RUN, drop MSS_LOCK for 1 cycle → both resets =1 and READY=0 at lock_q-fall+1; LOCK_LOST=1; LOSS_COUNT=1. Relock completes the sequence again. Repeat 300 losses → LOSS_COUNT=255.
- REQUIRE_MSS_LOCK=0 with MSS_LOCK held 0 → bring-up completes as in the clean case; setting REQUIRE_MSS_LOCK=1 in RUN → loss event, LOSS_COUNT increments.
- Timeout: lock held low for 70 cycles → TIMEOUT_ERR=1 after edge 31; STATE stays 0. CLR_STATUS pulse → TIMEOUT_ERR=0, then 1 again 32 cycles later. CLR_STATUS coincident with a loss event → LOCK_LOST=1, LOSS_COUNT=1.
- Reset mid-sequence: FAB_RESET for 1 cycle during RELEASE_CORE → CORE_RESET=1, STATE=0, counters 0. With lock held high, the full 8+4-cycle sequence repeats from edge 0.
